// File: rtl/adc_serial_capture_param.sv
// Parametrised serial-ADC capture front end.
// Drives cs_n/sclk and paces conversions from a sample timer. It shifts in
// MSB-first frames of LEAD_BITS+DATA_W bits and discards the leading bits,
// then keeps a result history and a sticky overrun flag.
// Optional feature macro: ADC_AVG_EN (registered history average on promedio).
module adc_serial_capture_param #(
    parameter int unsigned DATA_W        = 12,
    parameter int unsigned LEAD_BITS     = 4,
    parameter int unsigned SCLK_HALF     = 50,
    parameter int unsigned SAMPLE_PERIOD = 2272,
    parameter int unsigned HIST_DEPTH    = 4
) (
    input  logic                         clk100MHz,
    input  logic                         reset,
    input  logic                         inicioADC,
    input  logic                         modo,
    input  logic                         dato_SerieADC,
    output logic                         cs_n,
    output logic                         sclk,
    output logic                         listoControl,
    output logic [DATA_W-1:0]            Resultado,
    output logic [HIST_DEPTH*DATA_W-1:0] historial,
    output logic                         overrun,
    output logic [DATA_W-1:0]            promedio
);

    localparam int unsigned N_BITS = LEAD_BITS + DATA_W;
    localparam int unsigned HIST_W = HIST_DEPTH * DATA_W;
    localparam int unsigned HC_W   = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int unsigned BC_W   = $clog2(N_BITS);
    localparam int unsigned T_W    = $clog2(SAMPLE_PERIOD);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        QUIET = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [T_W-1:0]      tmr_q, tmr_d;
    logic [HC_W-1:0]     hc_q, hc_d;
    logic [BC_W-1:0]     bc_q, bc_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic                ini_q, ini_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                listo_q, listo_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic                ovr_q, ovr_d;

    logic tick_c;
    logic rise_c;
    logic req_c;
    logic hc_last_c;

    // State, timer and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            hc_q    <= '0;
            bc_q    <= '0;
            sr_q    <= '0;
            ini_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            listo_q <= 1'b0;
            res_q   <= '0;
            hist_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            hc_q    <= hc_d;
            bc_q    <= bc_d;
            sr_q    <= sr_d;
            ini_q   <= ini_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            listo_q <= listo_d;
            res_q   <= res_d;
            hist_q  <= hist_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state, serial timing, capture and overrun logic.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        bc_d    = bc_q;
        sr_d    = sr_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        listo_d = 1'b0;
        res_d   = res_q;
        hist_d  = hist_q;
        ovr_d   = ovr_q;
        ini_d   = inicioADC;

        tick_c    = (tmr_q == T_W'(SAMPLE_PERIOD - 1));
        tmr_d     = tick_c ? '0 : tmr_q + 1'b1;
        rise_c    = inicioADC & ~ini_q;
        req_c     = modo ? rise_c : (tick_c & inicioADC);
        hc_last_c = (hc_q == HC_W'(SCLK_HALF - 1));

        case (state_q)
            IDLE: begin
                if (req_c) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    hc_d    = '0;
                    bc_d    = '0;
                end
            end
            SETUP: begin
                if (hc_last_c) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                    hc_d    = '0;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            SHIFT: begin
                if (!hc_last_c) begin
                    hc_d = hc_q + 1'b1;
                end else begin
                    hc_d = '0;
                    if (!sclk_q) begin
                        // sclk rising edge: sample the data line
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[DATA_W-2:0], dato_SerieADC};
                        if (bc_q == BC_W'(N_BITS - 1)) begin
                            state_d = DONE;
                            cs_n_d  = 1'b1;
                            listo_d = 1'b1;
                            res_d   = sr_d;
                            hist_d  = (hist_q << DATA_W) | HIST_W'(sr_d);
                        end else begin
                            bc_d = bc_q + 1'b1;
                        end
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = QUIET;
                hc_d    = '0;
            end
            QUIET: begin
                if (hc_last_c) begin
                    state_d = IDLE;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase

        if ((state_q != IDLE) && req_c) begin
            ovr_d = 1'b1;
        end
    end

    assign cs_n         = cs_n_q;
    assign sclk         = sclk_q;
    assign listoControl = listo_q;
    assign Resultado    = res_q;
    assign historial    = hist_q;
    assign overrun      = ovr_q;

`ifdef ADC_AVG_EN
    localparam int unsigned LOG_D = $clog2(HIST_DEPTH);
    localparam int unsigned SUM_W = DATA_W + LOG_D;

    if ((1 << LOG_D) != HIST_DEPTH) begin : g_depth_chk
        $error("adc_serial_capture_param: HIST_DEPTH must be a power of two with ADC_AVG_EN");
    end

    logic [SUM_W-1:0]  sum_c;
    logic [DATA_W-1:0] prom_q, prom_d;

    // Sum of all history slices; averaged value captured after each new result.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(HIST_DEPTH); i++) begin
            sum_c = sum_c + SUM_W'(hist_q[i*DATA_W +: DATA_W]);
        end
        prom_d = listo_q ? DATA_W'(sum_c >> LOG_D) : prom_q;
    end

    // Average register.
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            prom_q <= '0;
        end else begin
            prom_q <= prom_d;
        end
    end

    assign promedio = prom_q;
`else
    assign promedio = '0;
`endif

endmodule

// File: tb/tb_adc_serial_capture_param.sv
// Scoreboard bench for adc_serial_capture_param: a serial ADC model feeds
// frames, expected results are queued with each frame and popped on listoControl.
module tb_adc_serial_capture_param;

    localparam int unsigned DW = 8;
    localparam int unsigned LB = 2;
    localparam int unsigned SH = 2;
    localparam int unsigned SP = 64;
    localparam int unsigned HD = 4;
    localparam int unsigned NB = LB + DW;

    logic            clk100MHz = 1'b0;
    logic            reset;
    logic            inicioADC;
    logic            modo;
    logic            dato_SerieADC;
    logic            cs_n;
    logic            sclk;
    logic            listoControl;
    logic [DW-1:0]   Resultado;
    logic [HD*DW-1:0] historial;
    logic            overrun;
    logic [DW-1:0]   promedio;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NB-1:0] frames[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] hm[HD];

    // serial ADC model state
    logic [NB-1:0] cur;
    int idx, rises, low_cnt, last_rises, last_low;
    logic cs_prev, sclk_prev;

    adc_serial_capture_param #(
        .DATA_W(DW), .LEAD_BITS(LB), .SCLK_HALF(SH),
        .SAMPLE_PERIOD(SP), .HIST_DEPTH(HD)
    ) dut (
        .clk100MHz    (clk100MHz),
        .reset        (reset),
        .inicioADC    (inicioADC),
        .modo         (modo),
        .dato_SerieADC(dato_SerieADC),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .listoControl (listoControl),
        .Resultado    (Resultado),
        .historial    (historial),
        .overrun      (overrun),
        .promedio     (promedio)
    );

    always #5 clk100MHz = ~clk100MHz;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ADC model: new bit presented after each sclk fall, frame popped at cs_n fall
    always @(negedge clk100MHz) begin
        if (reset) begin
            cs_prev   = 1'b1;
            sclk_prev = 1'b1;
            idx       = 0;
        end else begin
            if (!cs_n && cs_prev) begin
                cur     = (frames.size() > 0) ? frames.pop_front() : '0;
                idx     = 0;
                rises   = 0;
                low_cnt = 0;
            end
            if (!cs_n) low_cnt++;
            if (sclk && !sclk_prev && !cs_prev) rises++;
            if (cs_n && !cs_prev) begin
                last_rises = rises;
                last_low   = low_cnt;
            end
            if (!cs_n && !sclk && sclk_prev && idx < int'(NB)) begin
                dato_SerieADC = cur[NB-1-idx];
                idx++;
            end
            cs_prev   = cs_n;
            sclk_prev = sclk;
        end
    end

    function automatic logic [HD*DW-1:0] hist_exp();
        logic [HD*DW-1:0] r;
        for (int i = 0; i < int'(HD); i++) r[i*DW +: DW] = hm[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] avg_exp();
`ifdef ADC_AVG_EN
        int s;
        s = 0;
        for (int i = 0; i < int'(HD); i++) s += int'(hm[i]);
        return DW'(s / int'(HD));
`else
        return '0;
`endif
    endfunction

    task automatic model_push(input logic [DW-1:0] v);
        for (int i = int'(HD) - 1; i > 0; i--) hm[i] = hm[i-1];
        hm[0] = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(HD); i++) hm[i] = '0;
    endtask

    task automatic send_frame(input logic [NB-1:0] w, input bit expect_result);
        frames.push_back(w);
        if (expect_result) exp_q.push_back(DW'(w));
    endtask

    task automatic wait_listo(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk100MHz);
            if (listoControl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk100MHz);
        inicioADC = 1'b1;
        repeat (2) @(negedge clk100MHz);
        inicioADC = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; inicioADC = 1'b0; modo = 1'b0; dato_SerieADC = 1'b0;
        model_clear();
        repeat (3) @(negedge clk100MHz);
        n_tests++;
        if ({cs_n, sclk, listoControl, overrun} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_ctrl: cs_n,sclk,listo,overrun=%b expected 1100", {cs_n, sclk, listoControl, overrun});
        end
        n_tests++;
        if (Resultado !== '0 || historial !== '0 || promedio !== '0) begin
            n_fail++;
            $display("FAIL reset_data: Resultado=%h historial=%h promedio=%h expected 0", Resultado, historial, promedio);
        end
        reset = 1'b0;
        repeat (SP / 2) @(negedge clk100MHz);
        n_tests++;
        if (cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_no_start: cs_n=%b expected 1 with inicioADC=0", cs_n);
        end
    endtask

    task automatic test_continuous();
        bit ok;
        logic [DW-1:0] e;
        send_frame(10'b10_1000_0001, 1'b1);
        send_frame(10'b01_0101_1010, 1'b1);
        send_frame(10'b11_1111_1110, 1'b1);
        modo = 1'b0;
        inicioADC = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_listo(4 * SP, ok);
            if (k == 2) inicioADC = 1'b0;
            n_tests++;
            if (!ok || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cont_listo%0d: no result (ok=%0d queued=%0d) expected one", k, ok, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                model_push(e);
                n_tests++;
                if (Resultado !== e) begin
                    n_fail++;
                    $display("FAIL cont_result%0d: Resultado=%h expected %h", k, Resultado, e);
                end
                n_tests++;
                if (historial !== hist_exp()) begin
                    n_fail++;
                    $display("FAIL cont_hist%0d: historial=%h expected %h", k, historial, hist_exp());
                end
                @(negedge clk100MHz);
                n_tests++;
                if (listoControl !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cont_pulse%0d: listoControl=%b expected 0 one cycle later", k, listoControl);
                end
                n_tests++;
                if (last_rises != int'(NB) || last_low != int'(2 * NB * SH)) begin
                    n_fail++;
                    $display("FAIL cont_frame%0d: sclk rises=%0d cs_n low=%0d expected %0d and %0d",
                             k, last_rises, last_low, NB, 2 * NB * SH);
                end
                n_tests++;
                if (promedio !== avg_exp()) begin
                    n_fail++;
                    $display("FAIL cont_avg%0d: promedio=%h expected %h", k, promedio, avg_exp());
                end
            end
        end
        repeat (2 * SP) @(negedge clk100MHz);
        n_tests++;
        if (frames.size() != 0 || exp_q.size() != 0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_stop: frames left=%0d results left=%0d overrun=%b expected 0,0,0",
                     frames.size(), exp_q.size(), overrun);
        end
    endtask

    task automatic test_single_shot_overrun();
        bit ok;
        int extra;
        logic [DW-1:0] e;
        modo = 1'b1;
        send_frame(10'b00_1100_0011, 1'b1);
        pulse_start();
        repeat (20) @(negedge clk100MHz);
        n_tests++;
        if (overrun !== 1'b0 || cs_n !== 1'b0) begin
            n_fail++;
            $display("FAIL ss_busy: overrun=%b cs_n=%b expected 0,0 mid-frame", overrun, cs_n);
        end
        pulse_start();
        wait_listo(200, ok);
        n_tests++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ss_listo: no result (ok=%0d) expected one", ok);
        end else begin
            e = exp_q.pop_front();
            model_push(e);
            n_tests++;
            if (Resultado !== e || historial !== hist_exp()) begin
                n_fail++;
                $display("FAIL ss_result: Resultado=%h historial=%h expected %h %h", Resultado, historial, e, hist_exp());
            end
        end
        extra = 0;
        repeat (150) begin
            @(negedge clk100MHz);
            if (listoControl) extra++;
        end
        n_tests++;
        if (extra != 0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ss_overrun: extra results=%0d overrun=%b expected 0 and 1", extra, overrun);
        end
        n_tests++;
        if (Resultado !== hm[0]) begin
            n_fail++;
            $display("FAIL ss_hold: Resultado=%h expected %h", Resultado, hm[0]);
        end
        // clean frame, inicioADC held high across sample ticks
        send_frame(10'b10_0011_1100, 1'b1);
        @(negedge clk100MHz);
        inicioADC = 1'b1;
        wait_listo(200, ok);
        n_tests++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ss_clean_listo: no result (ok=%0d) expected one", ok);
        end else begin
            e = exp_q.pop_front();
            model_push(e);
            n_tests++;
            if (Resultado !== e || historial !== hist_exp()) begin
                n_fail++;
                $display("FAIL ss_clean_result: Resultado=%h historial=%h expected %h %h", Resultado, historial, e, hist_exp());
            end
            @(negedge clk100MHz);
            n_tests++;
            if (promedio !== avg_exp()) begin
                n_fail++;
                $display("FAIL ss_avg: promedio=%h expected %h", promedio, avg_exp());
            end
        end
        extra = 0;
        repeat (3 * SP) begin
            @(negedge clk100MHz);
            if (listoControl) extra++;
        end
        inicioADC = 1'b0;
        n_tests++;
        if (extra != 0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ss_tick_ignored: extra results=%0d overrun=%b expected 0 and 1", extra, overrun);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int nr;
        logic sp;
        logic [DW-1:0] e;
        modo = 1'b1;
        send_frame(10'b11_1111_1111, 1'b0);
        pulse_start();
        nr = 0;
        sp = sclk;
        for (int i = 0; i < 200 && nr < 2; i++) begin
            @(negedge clk100MHz);
            if (sclk && !sp && !cs_n) nr++;
            sp = sclk;
        end
        reset = 1'b1;
        #1;
        model_clear();
        n_tests++;
        if (nr != 2 || cs_n !== 1'b1 || sclk !== 1'b1 || Resultado !== '0 || historial !== '0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: rises=%0d cs_n=%b sclk=%b Resultado=%h historial=%h overrun=%b expected 2,1,1,0,0,0",
                     nr, cs_n, sclk, Resultado, historial, overrun);
        end
        @(negedge clk100MHz);
        reset = 1'b0;
        send_frame(10'b00_1010_0101, 1'b1);
        pulse_start();
        wait_listo(200, ok);
        n_tests++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL postreset_listo: no result (ok=%0d) expected one", ok);
        end else begin
            e = exp_q.pop_front();
            model_push(e);
            n_tests++;
            if (Resultado !== e || historial !== hist_exp()) begin
                n_fail++;
                $display("FAIL postreset_result: Resultado=%h historial=%h expected %h %h", Resultado, historial, e, hist_exp());
            end
            @(negedge clk100MHz);
            n_tests++;
            if (promedio !== avg_exp() || last_rises != int'(NB)) begin
                n_fail++;
                $display("FAIL postreset_frame: promedio=%h rises=%0d expected %h and %0d", promedio, last_rises, avg_exp(), NB);
            end
        end
    endtask

    initial begin
        cs_prev = 1'b1; sclk_prev = 1'b1; idx = 0;
        rises = 0; low_cnt = 0; last_rises = 0; last_low = 0;
        test_reset();
        test_continuous();
        test_single_shot_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
